// File: rtl/bidir_dir_ctrl.sv
// Half-duplex direction controller for the shared A<->B bidirectional buffer.
// Arbitrates side requests, drives cntrl/drive_en and inserts dead cycles on turnaround.
module bidir_dir_ctrl #(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic grant_a,
  output logic grant_b,
  output logic cntrl,
  output logic drive_en,
  output logic busy
);

  localparam int unsigned TW = 4;
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TURN  = 2'd1;
  localparam logic [1:0] S_OWN_A = 2'd2;
  localparam logic [1:0] S_OWN_B = 2'd3;

  localparam logic [TW-1:0] TURN_LOAD  = TW'(TURNAROUND - 1);
  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

  logic [1:0]    r_state;
  logic [TW-1:0] r_turn_cnt;
  logic [BW-1:0] r_burst_cnt;
  logic          r_last_a;
  logic          r_target_a;

  logic [1:0]    w_next_state;
  logic          w_next_cntrl;
  logic [TW-1:0] w_next_turn;
  logic [BW-1:0] w_next_burst;
  logic          w_next_last_a;
  logic          w_next_target_a;
  logic          w_idle_tgt_a;
  logic          w_target_req;

  // Next-state and counter logic; outputs are registered from the next state.
  always_comb begin
    w_next_state    = r_state;
    w_next_cntrl    = cntrl;
    w_next_turn     = r_turn_cnt;
    w_next_burst    = r_burst_cnt;
    w_next_last_a   = r_last_a;
    w_next_target_a = r_target_a;
    // Sole requester wins; a tie goes to the side that did not own last.
    w_idle_tgt_a    = req_a & (~req_b | ~r_last_a);
    w_target_req    = r_target_a ? req_a : req_b;

    case (r_state)
      S_IDLE: begin
        if (req_a | req_b) begin
          if (w_idle_tgt_a == cntrl) begin
            w_next_state  = w_idle_tgt_a ? S_OWN_A : S_OWN_B;
            w_next_burst  = '0;
            w_next_last_a = w_idle_tgt_a;
          end else begin
            w_next_state    = S_TURN;
            w_next_cntrl    = w_idle_tgt_a;
            w_next_turn     = TURN_LOAD;
            w_next_target_a = w_idle_tgt_a;
          end
        end
      end
      S_TURN: begin
        if (r_turn_cnt == '0) begin
          if (w_target_req) begin
            w_next_state  = r_target_a ? S_OWN_A : S_OWN_B;
            w_next_burst  = '0;
            w_next_last_a = r_target_a;
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_turn = r_turn_cnt - TW'(1);
        end
      end
      S_OWN_A: begin
        if (!req_a || (r_burst_cnt == BURST_LAST && req_b)) begin
          if (req_b) begin
            w_next_state    = S_TURN;
            w_next_cntrl    = 1'b0;
            w_next_turn     = TURN_LOAD;
            w_next_target_a = 1'b0;
          end else begin
            w_next_state = S_IDLE;
          end
        end else if (r_burst_cnt == BURST_LAST) begin
          w_next_burst = '0;
        end else begin
          w_next_burst = r_burst_cnt + BW'(1);
        end
      end
      default: begin
        if (!req_b || (r_burst_cnt == BURST_LAST && req_a)) begin
          if (req_a) begin
            w_next_state    = S_TURN;
            w_next_cntrl    = 1'b1;
            w_next_turn     = TURN_LOAD;
            w_next_target_a = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end else if (r_burst_cnt == BURST_LAST) begin
          w_next_burst = '0;
        end else begin
          w_next_burst = r_burst_cnt + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_turn_cnt  <= '0;
      r_burst_cnt <= '0;
      r_last_a    <= 1'b0;
      r_target_a  <= 1'b0;
      grant_a     <= 1'b0;
      grant_b     <= 1'b0;
      cntrl       <= 1'b1;
      drive_en    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_turn_cnt  <= w_next_turn;
      r_burst_cnt <= w_next_burst;
      r_last_a    <= w_next_last_a;
      r_target_a  <= w_next_target_a;
      grant_a     <= (w_next_state == S_OWN_A);
      grant_b     <= (w_next_state == S_OWN_B);
      cntrl       <= w_next_cntrl;
      drive_en    <= (w_next_state == S_OWN_A) || (w_next_state == S_OWN_B);
      busy        <= (w_next_state != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bidir_dir_ctrl.sv
// Directed bench for bidir_dir_ctrl (TURNAROUND=2, MAX_BURST=16).
// Cycle k is the interval following the k-th rising edge after reset release.
module tb_bidir_dir_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic req_a;
  logic req_b;
  logic grant_a;
  logic grant_b;
  logic cntrl;
  logic drive_en;
  logic busy;

  int n_cmp = 0;
  int n_bad = 0;

  bidir_dir_ctrl #(.TURNAROUND(2), .MAX_BURST(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .grant_a  (grant_a),
    .grant_b  (grant_b),
    .cntrl    (cntrl),
    .drive_en (drive_en),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one cycle, then check the grant/drive invariants away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv_not_both_grants", grant_a & grant_b, 1'b0);
    chk("inv_grant_needs_de", (grant_a | grant_b) & ~drive_en, 1'b0);
    chk("inv_grant_a_dir", grant_a & ~cntrl, 1'b0);
    chk("inv_grant_b_dir", grant_b & cntrl, 1'b0);
  endtask

  task automatic chk_out(input string tag, input logic ga, input logic gb,
                         input logic c, input logic de, input logic b);
    chk({tag, "_grant_a"}, grant_a, ga);
    chk({tag, "_grant_b"}, grant_b, gb);
    chk({tag, "_cntrl"}, cntrl, c);
    chk({tag, "_drive_en"}, drive_en, de);
    chk({tag, "_busy"}, busy, b);
  endtask

  // Reset, check reset state, then run to cycle 5 with no requests.
  task automatic reset_to_c5();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    tick();
    chk_out("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    chk_out("idle_c5", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
    repeat (2) @(posedge clk);

    // 1: A alone, held 40 cycles, no gaps across burst wrap
    reset_to_c5();
    req_a = 1'b1;
    tick();
    chk_out("t1_c6", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int c = 7; c <= 45; c++) begin
      if (c == 45) req_a = 1'b0;
      if (c < 45) tick(); else ;
      chk("t1_hold_grant_a", grant_a, 1'b1);
    end
    tick();
    chk_out("t1_release", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // 2: B alone from idle: turnaround then grant
    reset_to_c5();
    req_b = 1'b1;
    tick();
    chk_out("t2_c6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t2_c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t2_c8", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

    // 3: tie: A first for 16, turn, B for 16, turn, A again
    reset_to_c5();
    req_a = 1'b1; req_b = 1'b1;
    for (int c = 6; c <= 21; c++) begin
      tick();
      chk("t3_a_burst", grant_a, 1'b1);
    end
    tick();
    chk_out("t3_c22", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t3_c23", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int c = 24; c <= 39; c++) begin
      tick();
      chk("t3_b_burst", grant_b, 1'b1);
    end
    tick();
    chk_out("t3_c40", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("t3_c41", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    tick();
    chk_out("t3_c42", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 4: A drops req, goes idle, re-request granted next cycle
    reset_to_c5();
    req_a = 1'b1;
    for (int c = 6; c <= 10; c++) begin
      tick();
      chk("t4_grant_a", grant_a, 1'b1);
    end
    req_a = 1'b0;
    tick();
    chk_out("t4_c11", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    req_a = 1'b1;
    tick();
    chk_out("t4_c12", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

    // 5: B abandons request during the dead cycles
    reset_to_c5();
    req_b = 1'b1;
    tick();
    chk_out("t5_c6", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    req_b = 1'b0;
    tick();
    chk_out("t5_c7", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("t5_c8", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("t5_c9", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset pulse while B owns the link
    reset_to_c5();
    req_b = 1'b1;
    repeat (3) tick();
    chk_out("t6_c8", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    tick();
    chk("t6_c10_grant_b", grant_b, 1'b1);
    rst = 1'b1;
    tick();
    chk_out("t6_c11", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_out("t6_c12", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
